// File: rtl/ins_loader.sv
// Boot loader + instruction RAM: parses SYNC/count/words/XOR frames into RAM, then serves the CPU fetch port.
// Latency: RAM write on the edge taking the last byte of a word; release on the checksum edge; INS_MEM is combinational.
// Backpressure: byte_ready is high in every loading state, so there are no stalls; it is low only in RUN/ERR.
module ins_loader #(
    parameter int              WIDTH    = 32,
    parameter int              ADDRSIZE = 12,
    parameter int              DEPTH    = 4096,
    parameter logic [7:0]      SYNC     = 8'hA5,
    parameter logic [WIDTH-1:0] FILL    = 32'h9000_0000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [7:0]          byte_data,
    input  logic                byte_valid,
    output logic                byte_ready,
    input  logic [ADDRSIZE-1:0] INS_ADDR,
    output logic [0:WIDTH-1]    INS_MEM,
    output logic                cpu_rst,
    output logic                load_done,
    output logic                load_err,
    output logic [12:0]         words_loaded
);

    localparam int NB = WIDTH / 8;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;

    typedef enum logic [2:0] {IDLE, CNT_HI, CNT_LO, DATA, CSUM, RUN, ERR} state_t;

    state_t             state, nxt;
    logic [15:0]        cnt;
    logic [15:0]        waddr;
    logic [BW-1:0]      bcnt;
    logic [7:0]         xsum;
    logic [WIDTH-9:0]   word;
    logic [WIDTH-1:0]   mem [0:DEPTH-1];

    logic               fire;
    logic               last_byte;
    logic [15:0]        cnt_next;
    logic [WIDTH-1:0]   full_word;

    assign byte_ready = (state != RUN) && (state != ERR);
    assign fire       = byte_valid && byte_ready;
    assign last_byte  = (bcnt == BW'(NB - 1));
    assign cnt_next   = {cnt[15:8], byte_data};
    assign full_word  = {word, byte_data};

    assign load_done  = (state == RUN);
    assign load_err   = (state == ERR);
    assign cpu_rst    = !load_done;

    // Fetch port: NOP while the CPU is held, FILL (HLT) beyond the loaded image.
    // Addresses and counts compared at 32 bits so ADDRSIZE and the 13-bit count may differ.
    assign INS_MEM = !load_done ? '0 :
                     (32'(INS_ADDR) < 32'(words_loaded)) ? mem[INS_ADDR] : FILL;

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) state <= IDLE;
        else      state <= nxt;
    end

    // Next-state decode; every transition is taken only on an accepted byte.
    always_comb begin
        nxt = state;
        case (state)
            IDLE:   if (fire && byte_data == SYNC) nxt = CNT_HI;
            CNT_HI: if (fire) nxt = CNT_LO;
            CNT_LO: if (fire) begin
                        if ({16'd0, cnt_next} > 32'(DEPTH)) nxt = ERR;
                        else if (cnt_next == 16'd0)         nxt = CSUM;
                        else                                nxt = DATA;
                    end
            DATA:   if (fire && last_byte && (waddr + 16'd1 == cnt)) nxt = CSUM;
            CSUM:   if (fire) nxt = (byte_data == xsum) ? RUN : ERR;
            default: nxt = state;
        endcase
    end

    // Frame datapath: count capture, word assembly, write pointer and running XOR.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt          <= '0;
            waddr        <= '0;
            bcnt         <= '0;
            xsum         <= '0;
            word         <= '0;
            words_loaded <= '0;
        end else begin
            case (state)
                IDLE: xsum <= '0;
                CNT_HI: if (fire) begin
                    cnt[15:8] <= byte_data;
                    xsum      <= xsum ^ byte_data;
                end
                CNT_LO: if (fire) begin
                    cnt[7:0] <= byte_data;
                    xsum     <= xsum ^ byte_data;
                    waddr    <= '0;
                    bcnt     <= '0;
                end
                DATA: if (fire) begin
                    xsum <= xsum ^ byte_data;
                    word <= full_word[WIDTH-9:0];
                    if (last_byte) begin
                        bcnt  <= '0;
                        waddr <= waddr + 16'd1;
                    end else begin
                        bcnt  <= bcnt + BW'(1);
                    end
                end
                CSUM: if (fire && byte_data == xsum) words_loaded <= cnt[12:0];
                default: ;
            endcase
        end
    end

    // RAM write on the byte that completes a word; contents survive reset and are masked by words_loaded.
    always_ff @(posedge clk) begin
        if (rst && state == DATA && fire && last_byte)
            mem[waddr[ADDRSIZE-1:0]] <= full_word;
    end

endmodule

// File: tb/tb_ins_loader.sv
module tb_ins_loader;

    logic        clk = 0;
    logic        rst = 0;
    logic [7:0]  byte_data = 0;
    logic        byte_valid = 0;
    logic        byte_ready;
    logic [11:0] ins_addr = 0;
    logic [31:0] ins_mem;
    logic        cpu_rst, load_done, load_err;
    logic [12:0] words_loaded;

    int checks = 0;
    int errors = 0;

    localparam logic [31:0] FILL = 32'h9000_0000;

    typedef struct {
        logic [11:0] addr;
        logic [31:0] data;
        string       name;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] frame_words[$];

    always #5 clk = ~clk;

    ins_loader dut (
        .clk(clk), .rst(rst), .byte_data(byte_data), .byte_valid(byte_valid),
        .byte_ready(byte_ready), .INS_ADDR(ins_addr), .INS_MEM(ins_mem),
        .cpu_rst(cpu_rst), .load_done(load_done), .load_err(load_err),
        .words_loaded(words_loaded)
    );

    task automatic do_reset(input int cycles);
        byte_valid = 0;
        rst = 0;
        repeat (cycles) @(posedge clk);
        #1 rst = 1;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        byte_data  = b;
        byte_valid = 1;
        @(posedge clk);
        #1 byte_valid = 0;
        repeat (gap) @(posedge clk);
        if (gap > 0) #1;
    endtask

    // Sends SYNC, count, frame_words and the XOR checksum; a good frame queues its read-back expectations.
    task automatic send_frame(input int gap, input logic corrupt, input string tag);
        logic [7:0]  x;
        logic [15:0] n;
        n = 16'(frame_words.size());
        x = n[15:8] ^ n[7:0];
        send_byte(8'hA5, gap);
        send_byte(n[15:8], gap);
        send_byte(n[7:0], gap);
        foreach (frame_words[i]) begin
            logic [31:0] w;
            w = frame_words[i];
            for (int k = 3; k >= 0; k--) begin
                x = x ^ w[k*8 +: 8];
                send_byte(w[k*8 +: 8], gap);
            end
            if (!corrupt) sb.push_back('{addr: 12'(i), data: w, name: $sformatf("%s_w%0d", tag, i)});
        end
        if (!corrupt) sb.push_back('{addr: 12'(n), data: FILL, name: {tag, "_fill"}});
        send_byte(corrupt ? (x ^ 8'h01) : x, 0);
    endtask

    task automatic drain_reads();
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            ins_addr = e.addr;
            #1;
            checks++;
            if (ins_mem !== e.data) begin
                errors++;
                $display("FAIL %s: INS_MEM got %h expected %h", e.name, ins_mem, e.data);
            end
        end
        ins_addr = 0;
    endtask

    task automatic check_status(input string name, input logic exp_done, input logic exp_err,
                                input logic [12:0] exp_words);
        checks++;
        if (load_done !== exp_done || load_err !== exp_err || cpu_rst !== !exp_done ||
            byte_ready !== !(exp_done || exp_err) || words_loaded !== exp_words) begin
            errors++;
            $display("FAIL %s: done=%b err=%b cpu_rst=%b rdy=%b words=%0d expected done=%b err=%b cpu_rst=%b rdy=%b words=%0d",
                     name, load_done, load_err, cpu_rst, byte_ready, words_loaded,
                     exp_done, exp_err, !exp_done, !(exp_done || exp_err), exp_words);
        end
    endtask

    task automatic test_reset();
        logic [11:0] addrs [3] = '{12'd0, 12'd5, 12'd4095};
        do_reset(2);
        check_status("reset_status", 0, 0, 0);
        foreach (addrs[i]) begin
            ins_addr = addrs[i];
            #1;
            checks++;
            if (ins_mem !== 32'h0) begin
                errors++;
                $display("FAIL reset_nop@%0d: INS_MEM got %h expected 0", addrs[i], ins_mem);
            end
        end
        ins_addr = 0;
    endtask

    task automatic test_single_word();
        do_reset(1);
        frame_words = '{32'h2000_5003};
        send_frame(0, 0, "single");
        check_status("single_status", 1, 0, 1);
        drain_reads();
        // Bytes offered in RUN must be ignored.
        send_byte(8'hA5, 0);
        check_status("single_run_ignores", 1, 0, 1);
    endtask

    task automatic test_bad_checksum();
        do_reset(1);
        frame_words = '{32'h2000_5003};
        send_frame(0, 1, "badcs");
        check_status("badcs_status", 0, 1, 0);
        ins_addr = 0;
        #1;
        checks++;
        if (ins_mem !== 32'h0) begin
            errors++;
            $display("FAIL badcs_nop: INS_MEM got %h expected 0", ins_mem);
        end
        send_byte(8'hA5, 0);
        check_status("badcs_err_sticky", 0, 1, 0);
    endtask

    task automatic test_junk_and_gaps();
        do_reset(1);
        send_byte(8'h00, 3);
        send_byte(8'hFF, 3);
        check_status("junk_idle", 0, 0, 0);
        frame_words = '{32'h1234_5678, 32'hDEAD_BEEF};
        send_frame(3, 0, "gaps");
        check_status("gaps_status", 1, 0, 2);
        drain_reads();
    endtask

    task automatic test_oversize_and_zero();
        do_reset(1);
        send_byte(8'hA5, 0);
        send_byte(8'h10, 0);
        check_status("oversize_mid", 0, 0, 0);
        send_byte(8'h01, 0);
        check_status("oversize_err", 0, 1, 0);

        do_reset(1);
        frame_words = {};
        send_frame(0, 0, "zero");
        check_status("zero_status", 1, 0, 0);
        drain_reads();
    endtask

    task automatic test_reset_mid_frame();
        do_reset(1);
        send_byte(8'hA5, 0);
        send_byte(8'h00, 0);
        send_byte(8'h01, 0);
        send_byte(8'hAB, 0);
        send_byte(8'hCD, 0);
        do_reset(1);
        check_status("midrst_status", 0, 0, 0);
        frame_words = '{32'h2000_5003};
        send_frame(0, 0, "midrst");
        check_status("midrst_done", 1, 0, 1);
        drain_reads();
        // Reset while running puts the CPU back into reset.
        do_reset(1);
        check_status("run_reset", 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_bad_checksum();
        test_junk_and_gaps();
        test_oversize_and_zero();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/ins_loader.md
# ins_loader

Boot-time instruction memory and loader that sits directly upstream of the CPU's instruction fetch port. It accepts a framed byte stream (sync byte, word count, big-endian instruction words, XOR checksum) over a valid/ready handshake and writes the words into an internal instruction RAM. While loading, it holds the CPU in reset. After a good frame it releases the CPU and serves `INS_MEM` combinationally from `INS_ADDR`.

## Interface
- `WIDTH`, 32, instruction word width (bit 0 = MSB, matches `INS_MEM [0:31]`)
- `ADDRSIZE`, 12, instruction address width
- `DEPTH`, 4096, RAM words; must be ≤ 2^ADDRSIZE
- `SYNC`, 8'hA5, frame start byte
- `FILL`, 32'h9000_0000, word returned for unloaded addresses (HLT opcode)

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous reset, active-low. Sampled at the rising edge of `clk`.
- `byte_data` in 8: stream byte.
- `byte_valid` in 1: `byte_data` is valid this cycle.
- `byte_ready` out 1: block accepts a byte this cycle.
- `INS_ADDR` in ADDRSIZE: CPU fetch address (CPU `pc`).
- `INS_MEM` out [0:WIDTH-1]: instruction at `INS_ADDR`, combinational.
- `cpu_rst` out 1: active-high reset to the CPU; 1 unless state is RUN.
- `load_done` out 1: state is RUN.
- `load_err` out 1: state is ERR.
- `words_loaded` out 13: accepted word count from the header.

## Operation
- A byte transfer occurs at a rising edge with `byte_valid && byte_ready`. No other byte is consumed.
- `byte_ready` is 1 in states IDLE, CNT_HI, CNT_LO, DATA and CSUM, and 0 in RUN and ERR.
- FSM transitions, each taken on a transfer:
  - IDLE: byte == SYNC → CNT_HI. Any other byte is discarded and the FSM stays in IDLE.
  - CNT_HI: store `cnt[15:8]` → CNT_LO.
  - CNT_LO: store `cnt[7:0]`. If `cnt > DEPTH` → ERR. If `cnt == 0` → CSUM. Otherwise → DATA with `waddr = 0` and `bcnt = 0`.
  - DATA: shift the byte into the word assembly register, MSB first; the first byte lands in `INS` bits 0..7 (`[31:24]`). On the 4th byte, write `mem[waddr]` and increment `waddr`. If `waddr + 1 == cnt` → CSUM.
  - CSUM: if byte == running XOR → RUN, else → ERR.
  - RUN and ERR are terminal. Only `rst` low leaves them, returning to IDLE.
- Running XOR: cleared in IDLE. It covers both count bytes and every data byte. It excludes SYNC and the checksum byte.
- `words_loaded` = `cnt[12:0]`. It is captured on entry to RUN and holds 0 otherwise.
- Read port:
  - `INS_MEM = mem[INS_ADDR]` when `load_done && INS_ADDR < words_loaded`.
  - `INS_MEM = FILL` when `load_done` and `INS_ADDR >= words_loaded`.
  - `INS_MEM = 0` (NOP) when not `load_done`.
- Reset clears the FSM, counters, XOR, `cnt` and `words_loaded`. RAM contents are not cleared; the unloaded region is masked by `FILL`.

## Timing
- In reset (`rst` = 0 at an edge): the next state is IDLE. After that edge: `byte_ready` = 1, `cpu_rst` = 1, `load_done` = 0, `load_err` = 0, `words_loaded` = 0, `INS_MEM` = 0.
- Throughput is one byte per cycle and there are no stall cycles inside a frame.
- RAM write occurs on the same edge that accepts the 4th byte of a word. A word is never readable before RUN.
- Release latency: the edge that accepts a correct checksum byte sets `load_done` = 1 and `cpu_rst` = 0 immediately after that edge.
  - The CPU leaves reset with `pc` = 0.
  - Its first fetch samples `INS_MEM` for address 0 on the following edge.
- Read path is combinational from `INS_ADDR` to `INS_MEM` with no register. This is required because the CPU latches `ir` on the same edge that advances `pc`.
- Gaps: `byte_valid` low for any number of cycles mid-frame leaves all state unchanged. There is no timeout.
- Reset mid-frame: the partial word is discarded and already-written words are masked. `rst` low in RUN reasserts `cpu_rst` after that edge.
- `byte_valid` high in RUN/ERR is ignored (`byte_ready` = 0).

## Test plan
- Reset then idle: hold `rst` = 0 for 2 cycles, release.
  - `cpu_rst` = 1, `byte_ready` = 1, `INS_MEM` = 0 for any `INS_ADDR`.
- Single-word frame: send A5 00 01 20 00 50 03 72 back-to-back.
  - After the last byte: `load_done` = 1, `cpu_rst` = 0, `words_loaded` = 1.
  - `INS_ADDR` = 0 → `INS_MEM` = 32'h2000_5003.
  - `INS_ADDR` = 1 → 32'h9000_0000.
- Bad checksum: same frame with last byte 73.
  - `load_err` = 1, `cpu_rst` stays 1, `byte_ready` = 0, `INS_MEM` = 0.
- Junk and gaps: send 00 FF before A5, and toggle `byte_valid` low for 3 cycles between every byte of a 2-word frame.
  - Result is identical to the back-to-back case.
  - Both words are read back correctly.
- Oversize and zero count:
  - Header A5 10 01 (4097) → ERR after the 3rd byte.
  - Separately, after reset, A5 00 00 00 → RUN with `words_loaded` = 0 and `INS_MEM` = FILL at address 0.
- Reset mid-frame: after 2 data bytes pull `rst` = 0 for 1 cycle, then send the good frame from the single-word test.
  - `load_done` = 1 and `INS_MEM` at address 0 = 32'h2000_5003.
